csr_cmd_decoder: RTL and testbench

CSR_CMD_DECODER -- requirements
Module: csr_cmd_decoder

---
 rtl/internal_pkg.sv | 28 ++
 rtl/csr_cmd_decoder.sv | 126 ++++++++++++
 tb/tb_csr_cmd_decoder.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/internal_pkg.sv
// Shared CSR types: MMIO write packet, cache-line address, register map and decoder states.
package internal_pkg;

    localparam int unsigned MMIO_ADDR_W = 16;
    localparam int unsigned MMIO_DATA_W = 64;
    localparam int unsigned CL_ADDR_W   = 42;

    typedef logic [CL_ADDR_W-1:0] t_ccip_clAddr;

    typedef struct packed {
        logic                   valid;
        logic [MMIO_ADDR_W-1:0] addr;
        logic [MMIO_DATA_W-1:0] data;
    } t_if_internal;

    // Register map in 32-bit-word units (byte offsets 0x400/0x408/0x410/0x418).
    localparam logic [MMIO_ADDR_W-1:0] CSR_SRC       = MMIO_ADDR_W'(16'h0100);
    localparam logic [MMIO_ADDR_W-1:0] CSR_DST       = MMIO_ADDR_W'(16'h0102);
    localparam logic [MMIO_ADDR_W-1:0] CSR_NUM_LINES = MMIO_ADDR_W'(16'h0104);
    localparam logic [MMIO_ADDR_W-1:0] CSR_CTRL      = MMIO_ADDR_W'(16'h0106);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } t_dec_state;

endpackage

// File: rtl/csr_cmd_decoder.sv
// Decodes MMIO writes into job descriptor registers and sequences one copy job
// (start pulse, per-line completion count, completion sync pulse).
module csr_cmd_decoder
    import internal_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  t_if_internal         pkt_in,
    input  logic                 done_line,
    output t_ccip_clAddr         src_addr,
    output t_ccip_clAddr         dst_addr,
    output logic [CNT_WIDTH-1:0] num_lines,
    output logic                 start,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] line_cnt,
    output logic                 sync
);

    t_dec_state             state_q, state_d;
    t_ccip_clAddr           src_q, src_d;
    t_ccip_clAddr           dst_q, dst_d;
    logic [CNT_WIDTH-1:0]   num_q, num_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   cnt_inc;
    logic                   start_q, start_d;
    logic                   busy_q, busy_d;
    logic                   sync_q, sync_d;
    logic                   ctrl_wr, ctrl_start, ctrl_clear;
    logic                   unused_data;

    assign unused_data = ^pkt_in.data;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        num_d   = num_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;
        sync_d  = 1'b0;

        ctrl_wr    = pkt_in.valid && (pkt_in.addr == CSR_CTRL);
        ctrl_start = ctrl_wr && pkt_in.data[0];
        ctrl_clear = ctrl_wr && pkt_in.data[1];
        cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);

        // Job descriptor is frozen while a job is running.
        if (pkt_in.valid && (state_q != S_RUN)) begin
            unique case (pkt_in.addr)
                CSR_SRC:       src_d = pkt_in.data[CL_ADDR_W-1:0];
                CSR_DST:       dst_d = pkt_in.data[CL_ADDR_W-1:0];
                CSR_NUM_LINES: num_d = pkt_in.data[CNT_WIDTH-1:0];
                default: ;
            endcase
        end

        unique case (state_q)
            S_IDLE: begin
                if (ctrl_start) begin
                    cnt_d = '0;
                    if (num_q != '0) begin
                        state_d = S_RUN;
                        start_d = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        sync_d  = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (done_line) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == num_q) begin
                        state_d = S_DONE;
                        sync_d  = 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Soft clear overrides everything, including a start bit in the same write.
        if (ctrl_clear) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            start_d = 1'b0;
            sync_d  = 1'b0;
        end

        busy_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            num_q   <= '0;
            cnt_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            num_q   <= num_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            sync_q  <= sync_d;
        end
    end

    assign src_addr  = src_q;
    assign dst_addr  = dst_q;
    assign num_lines = num_q;
    assign line_cnt  = cnt_q;
    assign start     = start_q;
    assign busy      = busy_q;
    assign sync      = sync_q;

endmodule

// File: tb/tb_csr_cmd_decoder.sv
// Self-checking bench for csr_cmd_decoder: table of per-cycle vectors checked
// through an expected-result queue, plus a back-to-back completion sequence.
module tb_csr_cmd_decoder;
    import internal_pkg::*;

    localparam int unsigned CW = 32;

    logic            clk;
    logic            reset;
    t_if_internal    pkt_in;
    logic            done_line;
    t_ccip_clAddr    src_addr, dst_addr;
    logic [CW-1:0]   num_lines, line_cnt;
    logic            start, busy, sync;

    int checks = 0;
    int errors = 0;

    csr_cmd_decoder #(.CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .pkt_in    (pkt_in),
        .done_line (done_line),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .num_lines (num_lines),
        .start     (start),
        .busy      (busy),
        .line_cnt  (line_cnt),
        .sync      (sync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          v;
        logic [15:0] addr;
        logic [63:0] data;
        bit          dl;
    } stim_t;

    typedef struct {
        logic [41:0] src;
        logic [41:0] dst;
        logic [31:0] num;
        bit          st;
        bit          bz;
        logic [31:0] cnt;
        bit          sy;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic row(input bit rst, input bit v, input logic [15:0] addr, input logic [63:0] data,
                       input bit dl, input logic [41:0] src, input logic [41:0] dst,
                       input logic [31:0] num, input bit st, input bit bz,
                       input logic [31:0] cnt, input bit sy);
        vec_t r;
        r.s = '{rst: rst, v: v, addr: addr, data: data, dl: dl};
        r.e = '{src: src, dst: dst, num: num, st: st, bz: bz, cnt: cnt, sy: sy};
        vecs.push_back(r);
    endtask

    task automatic drive(input stim_t s);
        reset         = s.rst;
        pkt_in.valid  = s.v;
        pkt_in.addr   = s.addr;
        pkt_in.data   = s.data;
        done_line     = s.dl;
    endtask

    task automatic idle_inputs();
        stim_t s;
        s = '{rst: 1'b0, v: 1'b0, addr: 16'h0, data: 64'h0, dl: 1'b0};
        drive(s);
    endtask

    task automatic check_outputs(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 64'd1, 64'd0);
            return;
        end
        e = exp_q.pop_front();
        chk({tag, "_src"},   64'(src_addr),  64'(e.src));
        chk({tag, "_dst"},   64'(dst_addr),  64'(e.dst));
        chk({tag, "_num"},   64'(num_lines), 64'(e.num));
        chk({tag, "_start"}, 64'(start),     64'(e.st));
        chk({tag, "_busy"},  64'(busy),      64'(e.bz));
        chk({tag, "_cnt"},   64'(line_cnt),  64'(e.cnt));
        chk({tag, "_sync"},  64'(sync),      64'(e.sy));
    endtask

    // One cycle: drive away from the edge, sample #1 after the edge.
    task automatic cycle(input stim_t s);
        @(negedge clk);
        drive(s);
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        stim_t s;
        int starts;
        int syncs;
        bit seen;
        logic [31:0] cnt_at_sync;

        reset = 1'b1;
        idle_inputs();
        reset = 1'b1;

        //   rst v  addr    data       dl  src     dst     num st bz cnt sy
        row(1, 0, 16'h000, 64'h0,      0, 42'h0,    42'h0,    0, 0, 0, 0, 0);
        row(1, 0, 16'h000, 64'h0,      0, 42'h0,    42'h0,    0, 0, 0, 0, 0);
        row(0, 1, 16'h100, 64'h1000,   0, 42'h1000, 42'h0,    0, 0, 0, 0, 0);
        row(0, 1, 16'h102, 64'h2000,   0, 42'h1000, 42'h2000, 0, 0, 0, 0, 0);
        row(0, 1, 16'h104, 64'h4,      0, 42'h1000, 42'h2000, 4, 0, 0, 0, 0);
        row(0, 1, 16'h101, 64'hFF,     0, 42'h1000, 42'h2000, 4, 0, 0, 0, 0);
        row(0, 1, 16'h106, 64'h1,      0, 42'h1000, 42'h2000, 4, 1, 1, 0, 0);
        row(0, 0, 16'h000, 64'h0,      0, 42'h1000, 42'h2000, 4, 0, 1, 0, 0);
        row(0, 1, 16'h106, 64'h1,      0, 42'h1000, 42'h2000, 4, 0, 1, 0, 0);
        row(0, 1, 16'h104, 64'h9,      0, 42'h1000, 42'h2000, 4, 0, 1, 0, 0);
        row(0, 1, 16'h100, 64'h7777,   0, 42'h1000, 42'h2000, 4, 0, 1, 0, 0);
        row(0, 0, 16'h000, 64'h0,      1, 42'h1000, 42'h2000, 4, 0, 1, 1, 0);
        row(0, 0, 16'h000, 64'h0,      1, 42'h1000, 42'h2000, 4, 0, 1, 2, 0);
        row(0, 0, 16'h000, 64'h0,      0, 42'h1000, 42'h2000, 4, 0, 1, 2, 0);
        row(0, 0, 16'h000, 64'h0,      1, 42'h1000, 42'h2000, 4, 0, 1, 3, 0);
        row(0, 0, 16'h000, 64'h0,      1, 42'h1000, 42'h2000, 4, 0, 0, 4, 1);
        row(0, 0, 16'h000, 64'h0,      1, 42'h1000, 42'h2000, 4, 0, 0, 4, 0);
        row(0, 0, 16'h000, 64'h0,      0, 42'h1000, 42'h2000, 4, 0, 0, 4, 0);
        // zero-length job: no start, sync one cycle after CTRL
        row(0, 1, 16'h104, 64'h0,      0, 42'h1000, 42'h2000, 0, 0, 0, 4, 0);
        row(0, 1, 16'h106, 64'h1,      0, 42'h1000, 42'h2000, 0, 0, 0, 0, 1);
        row(0, 0, 16'h000, 64'h0,      0, 42'h1000, 42'h2000, 0, 0, 0, 0, 0);
        // soft clear after two lines, start bit set in same write
        row(0, 1, 16'h104, 64'h4,      0, 42'h1000, 42'h2000, 4, 0, 0, 0, 0);
        row(0, 1, 16'h106, 64'h1,      0, 42'h1000, 42'h2000, 4, 1, 1, 0, 0);
        row(0, 0, 16'h000, 64'h0,      1, 42'h1000, 42'h2000, 4, 0, 1, 1, 0);
        row(0, 0, 16'h000, 64'h0,      1, 42'h1000, 42'h2000, 4, 0, 1, 2, 0);
        row(0, 1, 16'h106, 64'h3,      1, 42'h1000, 42'h2000, 4, 0, 0, 0, 0);
        row(0, 0, 16'h000, 64'h0,      1, 42'h1000, 42'h2000, 4, 0, 0, 0, 0);
        row(0, 0, 16'h000, 64'h0,      0, 42'h1000, 42'h2000, 4, 0, 0, 0, 0);
        // reset mid-RUN with done_line and a write in the same cycle
        row(0, 1, 16'h106, 64'h1,      0, 42'h1000, 42'h2000, 4, 1, 1, 0, 0);
        row(0, 0, 16'h000, 64'h0,      1, 42'h1000, 42'h2000, 4, 0, 1, 1, 0);
        row(1, 1, 16'h100, 64'h55,     1, 42'h0,    42'h0,    0, 0, 0, 0, 0);
        row(0, 0, 16'h000, 64'h0,      0, 42'h0,    42'h0,    0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].s);
            exp_q.push_back(vecs[i].e);
            @(posedge clk);
            #1;
            check_outputs($sformatf("v%0d", i));
        end

        // Two-line job with done_line held high across start and completion.
        s = '{rst: 1'b0, v: 1'b1, addr: 16'h104, data: 64'h2, dl: 1'b0};
        cycle(s);
        s = '{rst: 1'b0, v: 1'b1, addr: 16'h106, data: 64'h1, dl: 1'b0};
        cycle(s);
        starts = int'(start);
        syncs = 0;
        seen = 1'b0;
        cnt_at_sync = '0;
        s = '{rst: 1'b0, v: 1'b0, addr: 16'h0, data: 64'h0, dl: 1'b1};
        for (int k = 0; k < 10; k++) begin
            cycle(s);
            starts += int'(start);
            syncs  += int'(sync);
            if (sync) begin
                seen = 1'b1;
                cnt_at_sync = line_cnt;
            end
        end
        idle_inputs();
        chk("b2b_sync_seen",   64'(seen),        64'd1);
        chk("b2b_start_count", 64'(starts),      64'd1);
        chk("b2b_sync_count",  64'(syncs),       64'd1);
        chk("b2b_cnt_at_sync", 64'(cnt_at_sync), 64'd2);
        chk("b2b_cnt_held",    64'(line_cnt),    64'd2);
        chk("b2b_busy_low",    64'(busy),        64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
